// File: rtl/operand_fwd_stage_pkg.sv
// Shared pipeline definitions for the operand forwarding stage.
package operand_fwd_stage_pkg;

  // Operand source encodings reported on e_fwd_src.
  localparam logic [1:0] SRC_RF  = 2'd0;
  localparam logic [1:0] SRC_WB  = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;
  localparam logic [1:0] SRC_EX  = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/operand_fwd_stage_fwd_sel_port.sv
// Single-port operand selector: picks the youngest matching producer.
module fwd_sel_port
  import operand_fwd_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   rs_addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic [AW-1:0]   ex_rd,
  input  logic            ex_we,
  input  logic [XLEN-1:0] ex_data,
  input  logic [AW-1:0]   mem_rd,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_data,
  input  logic [AW-1:0]   wb_rd,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] sel_data,
  output logic [1:0]      sel_src,
  output logic            ex_hit
);

  logic addr_nz;
  logic mem_hit;
  logic wb_hit;

  // Match detection and EX > MEM > WB > RF priority; register 0 is hardwired zero.
  always_comb begin
    addr_nz  = (rs_addr != '0);
    ex_hit   = ex_we  && (ex_rd  == rs_addr) && addr_nz;
    mem_hit  = mem_we && (mem_rd == rs_addr) && addr_nz;
    wb_hit   = wb_we  && (wb_rd  == rs_addr) && addr_nz;
    sel_data = '0;
    sel_src  = SRC_RF;
    if (ex_hit) begin
      sel_data = ex_data;
      sel_src  = SRC_EX;
    end else if (mem_hit) begin
      sel_data = mem_data;
      sel_src  = SRC_MEM;
    end else if (wb_hit) begin
      sel_data = wb_data;
      sel_src  = SRC_WB;
    end else if (addr_nz) begin
      sel_data = rf_data;
    end
  end

endmodule

// File: rtl/operand_fwd_stage.sv
// Operand forwarding stage: per-port bypass select, load-use stall,
// one-entry output register and saturating statistics.
//
//   state    | meaning
//   ST_EMPTY | no operands held, e_valid=0
//   ST_FULL  | operands held for EX, e_valid=1
module operand_fwd_stage
  import operand_fwd_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NPORT = 2,
  parameter int AW    = 5,
  parameter int CW    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [NPORT*AW-1:0]   d_rs_addr,
  input  logic [NPORT-1:0]      d_rs_used,
  input  logic [NPORT*XLEN-1:0] d_rf_data,
  input  logic [AW-1:0]         ex_rd,
  input  logic                  ex_we,
  input  logic                  ex_is_load,
  input  logic [XLEN-1:0]       ex_data,
  input  logic [AW-1:0]         mem_rd,
  input  logic                  mem_we,
  input  logic [XLEN-1:0]       mem_data,
  input  logic [AW-1:0]         wb_rd,
  input  logic                  wb_we,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  output logic                  e_valid,
  input  logic                  e_ready,
  output logic [NPORT*XLEN-1:0] e_rs_data,
  output logic [NPORT*2-1:0]    e_fwd_src,
  output logic [CW-1:0]         fwd_cnt,
  output logic [CW-1:0]         stall_cnt
);

  out_state_e            state_q;
  out_state_e            state_d;
  logic [NPORT*XLEN-1:0] sel_data;
  logic [NPORT*2-1:0]    sel_src;
  logic [NPORT-1:0]      ex_hit;
  logic                  hazard;
  logic                  accept;
  logic                  load_en;
  logic                  any_fwd;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    fwd_sel_port #(.XLEN(XLEN), .AW(AW)) u_sel (
      .rs_addr  (d_rs_addr[p*AW +: AW]),
      .rf_data  (d_rf_data[p*XLEN +: XLEN]),
      .ex_rd    (ex_rd),
      .ex_we    (ex_we),
      .ex_data  (ex_data),
      .mem_rd   (mem_rd),
      .mem_we   (mem_we),
      .mem_data (mem_data),
      .wb_rd    (wb_rd),
      .wb_we    (wb_we),
      .wb_data  (wb_data),
      .sel_data (sel_data[p*XLEN +: XLEN]),
      .sel_src  (sel_src[p*2 +: 2]),
      .ex_hit   (ex_hit[p])
    );
  end

  // Hazard, handshake and forwarding-statistic qualifiers; only used ports count.
  always_comb begin
    hazard  = d_valid && ex_is_load && |(d_rs_used & ex_hit);
    d_ready = !hazard && (!e_valid || e_ready);
    accept  = d_valid && d_ready;
    load_en = accept && !flush;
    any_fwd = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      if (d_rs_used[p] && (sel_src[p*2 +: 2] != SRC_RF)) any_fwd = 1'b1;
    end
  end

  assign e_valid = (state_q == ST_FULL);

  // Output-entry state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state: flush wins, then accept, then drain on e_ready.
  always_comb begin
    state_d = state_q;
    if (flush)                            state_d = ST_EMPTY;
    else if (accept)                      state_d = ST_FULL;
    else if (state_q == ST_FULL && e_ready) state_d = ST_EMPTY;
  end

  // Operand payload: loaded only on a surviving accept, otherwise held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_rs_data <= '0;
      e_fwd_src <= '0;
    end else if (load_en) begin
      e_rs_data <= sel_data;
      e_fwd_src <= sel_src;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (load_en && any_fwd && (fwd_cnt != '1))   fwd_cnt   <= fwd_cnt + CW'(1);
      if (hazard && !flush && (stall_cnt != '1))   stall_cnt <= stall_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_operand_fwd_stage.sv
module tb_operand_fwd_stage;
  localparam int XLEN  = 32;
  localparam int NPORT = 2;
  localparam int AW    = 5;
  localparam int CW    = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  d_valid;
  logic                  d_ready;
  logic [NPORT*AW-1:0]   d_rs_addr;
  logic [NPORT-1:0]      d_rs_used;
  logic [NPORT*XLEN-1:0] d_rf_data;
  logic [AW-1:0]         ex_rd, mem_rd, wb_rd;
  logic                  ex_we, ex_is_load, mem_we, wb_we;
  logic [XLEN-1:0]       ex_data, mem_data, wb_data;
  logic                  flush;
  logic                  e_valid;
  logic                  e_ready;
  logic [NPORT*XLEN-1:0] e_rs_data;
  logic [NPORT*2-1:0]    e_fwd_src;
  logic [CW-1:0]         fwd_cnt, stall_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  operand_fwd_stage #(.XLEN(XLEN), .NPORT(NPORT), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_ready(d_ready),
    .d_rs_addr(d_rs_addr), .d_rs_used(d_rs_used), .d_rf_data(d_rf_data),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_data(ex_data),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_data(mem_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .flush(flush), .e_valid(e_valid), .e_ready(e_ready),
    .e_rs_data(e_rs_data), .e_fwd_src(e_fwd_src),
    .fwd_cnt(fwd_cnt), .stall_cnt(stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    d_valid = 0; d_rs_addr = '0; d_rs_used = '0; d_rf_data = '0;
    ex_rd = '0; ex_we = 0; ex_is_load = 0; ex_data = '0;
    mem_rd = '0; mem_we = 0; mem_data = '0;
    wb_rd = '0; wb_we = 0; wb_data = '0;
    flush = 0; e_ready = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    step(); step();
    total_cnt++; if (e_valid !== 1'b0) $display("FAIL reset_e_valid got %0b exp 0", e_valid); else pass_cnt++;
    total_cnt++; if (e_rs_data !== '0) $display("FAIL reset_e_rs_data got %h exp 0", e_rs_data); else pass_cnt++;
    total_cnt++; if (e_fwd_src !== '0) $display("FAIL reset_e_fwd_src got %h exp 0", e_fwd_src); else pass_cnt++;
    total_cnt++; if (fwd_cnt !== 4'd0 || stall_cnt !== 4'd0) $display("FAIL reset_counters got %0d/%0d exp 0/0", fwd_cnt, stall_cnt); else pass_cnt++;
    total_cnt++; if (d_ready !== 1'b1) $display("FAIL reset_d_ready got %0b exp 1", d_ready); else pass_cnt++;
    rst_n = 1;
    step();
  endtask

  task automatic test_ex_priority();
    clear_inputs();
    d_valid = 1; d_rs_addr = {5'd0, 5'd5}; d_rs_used = 2'b01;
    d_rf_data = {32'h2222, 32'h1111};
    ex_rd = 5; ex_we = 1; ex_data = 32'hAAAA;
    mem_rd = 5; mem_we = 1; mem_data = 32'hBBBB;
    wb_rd = 5; wb_we = 1; wb_data = 32'hCCCC;
    settle();
    total_cnt++; if (d_ready !== 1'b1) $display("FAIL ex_prio_d_ready got %0b exp 1", d_ready); else pass_cnt++;
    step();
    d_valid = 0;
    total_cnt++; if (e_valid !== 1'b1) $display("FAIL ex_prio_e_valid got %0b exp 1", e_valid); else pass_cnt++;
    total_cnt++; if (e_rs_data !== {32'h0, 32'hAAAA}) $display("FAIL ex_prio_data got %h exp %h", e_rs_data, {32'h0, 32'hAAAA}); else pass_cnt++;
    total_cnt++; if (e_fwd_src !== 4'b0011) $display("FAIL ex_prio_src got %b exp 0011", e_fwd_src); else pass_cnt++;
    total_cnt++; if (fwd_cnt !== 4'd1) $display("FAIL ex_prio_fwd_cnt got %0d exp 1", fwd_cnt); else pass_cnt++;
    step();
    total_cnt++; if (e_valid !== 1'b0) $display("FAIL ex_prio_drain got %0b exp 0", e_valid); else pass_cnt++;
  endtask

  task automatic test_priority_chain();
    clear_inputs();
    d_valid = 1; d_rs_addr = {5'd10, 5'd9}; d_rs_used = 2'b11;
    d_rf_data = {32'h10, 32'h9};
    ex_rd = 9; ex_we = 0; ex_data = 32'hDEAD;
    mem_rd = 9; mem_we = 1; mem_data = 32'hBEEF;
    wb_rd = 9; wb_we = 1; wb_data = 32'hCAFE;
    step();
    total_cnt++; if (e_rs_data !== {32'h10, 32'hBEEF}) $display("FAIL mem_rf_data got %h exp %h", e_rs_data, {32'h10, 32'hBEEF}); else pass_cnt++;
    total_cnt++; if (e_fwd_src !== 4'b0010) $display("FAIL mem_rf_src got %b exp 0010", e_fwd_src); else pass_cnt++;
    total_cnt++; if (fwd_cnt !== 4'd2) $display("FAIL mem_rf_fwd_cnt got %0d exp 2", fwd_cnt); else pass_cnt++;
    // port0 from WB; port1 unused but matches an EX load: no stall, data still captured
    d_rs_addr = {5'd3, 5'd9}; d_rs_used = 2'b01;
    mem_we = 0;
    ex_rd = 3; ex_we = 1; ex_is_load = 1; ex_data = 32'h3333;
    settle();
    total_cnt++; if (d_ready !== 1'b1) $display("FAIL unused_no_hazard got %0b exp 1", d_ready); else pass_cnt++;
    step();
    d_valid = 0;
    total_cnt++; if (e_rs_data !== {32'h3333, 32'hCAFE}) $display("FAIL wb_unused_data got %h exp %h", e_rs_data, {32'h3333, 32'hCAFE}); else pass_cnt++;
    total_cnt++; if (e_fwd_src !== 4'b1101) $display("FAIL wb_unused_src got %b exp 1101", e_fwd_src); else pass_cnt++;
    total_cnt++; if (fwd_cnt !== 4'd3 || stall_cnt !== 4'd0) $display("FAIL wb_unused_cnts got %0d/%0d exp 3/0", fwd_cnt, stall_cnt); else pass_cnt++;
    step();
  endtask

  task automatic test_zero_addr();
    clear_inputs();
    d_valid = 1; d_rs_addr = '0; d_rs_used = 2'b01;
    d_rf_data = {32'hFFFF, 32'hFFFF};
    wb_rd = 0; wb_we = 1; wb_data = 32'h1234;
    ex_rd = 0; ex_we = 1; ex_data = 32'h5678;
    step();
    d_valid = 0;
    total_cnt++; if (e_rs_data !== '0) $display("FAIL zero_addr_data got %h exp 0", e_rs_data); else pass_cnt++;
    total_cnt++; if (e_fwd_src !== 4'b0000) $display("FAIL zero_addr_src got %b exp 0000", e_fwd_src); else pass_cnt++;
    total_cnt++; if (fwd_cnt !== 4'd3) $display("FAIL zero_addr_fwd_cnt got %0d exp 3", fwd_cnt); else pass_cnt++;
    step();
  endtask

  task automatic test_load_use();
    clear_inputs();
    d_valid = 1; d_rs_addr = {5'd7, 5'd0}; d_rs_used = 2'b10;
    ex_rd = 7; ex_we = 1; ex_is_load = 1; ex_data = 32'h99;
    settle();
    total_cnt++; if (d_ready !== 1'b0) $display("FAIL load_use_d_ready got %0b exp 0", d_ready); else pass_cnt++;
    step();
    total_cnt++; if (stall_cnt !== 4'd1 || e_valid !== 1'b0) $display("FAIL load_use_stall got cnt %0d ev %0b exp 1/0", stall_cnt, e_valid); else pass_cnt++;
    ex_we = 0; ex_is_load = 0;
    mem_rd = 7; mem_we = 1; mem_data = 32'h55;
    settle();
    total_cnt++; if (d_ready !== 1'b1) $display("FAIL load_use_release got %0b exp 1", d_ready); else pass_cnt++;
    step();
    d_valid = 0;
    total_cnt++; if (e_valid !== 1'b1 || e_rs_data[63:32] !== 32'h55) $display("FAIL load_use_data got ev %0b %h exp 1 55", e_valid, e_rs_data[63:32]); else pass_cnt++;
    total_cnt++; if (e_fwd_src[3:2] !== 2'd2) $display("FAIL load_use_src got %0d exp 2", e_fwd_src[3:2]); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 4'd1 || fwd_cnt !== 4'd4) $display("FAIL load_use_cnts got %0d/%0d exp 1/4", stall_cnt, fwd_cnt); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    // entry is FULL from the load-use test
    clear_inputs();
    e_ready = 0;
    d_valid = 1; d_rs_addr = {5'd0, 5'd4}; d_rs_used = 2'b01;
    d_rf_data = {32'h0, 32'h44};
    for (int i = 0; i < 3; i++) begin
      settle();
      total_cnt++; if (d_ready !== 1'b0) $display("FAIL bp_d_ready cyc %0d got %0b exp 0", i, d_ready); else pass_cnt++;
      step();
      total_cnt++; if (e_valid !== 1'b1 || e_rs_data !== {32'h55, 32'h0}) $display("FAIL bp_hold cyc %0d got ev %0b %h exp 1 %h", i, e_valid, e_rs_data, {32'h55, 32'h0}); else pass_cnt++;
    end
    e_ready = 1;
    settle();
    total_cnt++; if (d_ready !== 1'b1) $display("FAIL bp_release got %0b exp 1", d_ready); else pass_cnt++;
    step();
    d_valid = 0;
    total_cnt++; if (e_valid !== 1'b1 || e_rs_data !== {32'h0, 32'h44} || e_fwd_src !== 4'b0000) $display("FAIL bp_new_load got ev %0b %h %b exp 1 %h 0000", e_valid, e_rs_data, e_fwd_src, {32'h0, 32'h44}); else pass_cnt++;
    total_cnt++; if (fwd_cnt !== 4'd4) $display("FAIL bp_fwd_cnt got %0d exp 4", fwd_cnt); else pass_cnt++;
    step();
  endtask

  task automatic test_flush_and_reset();
    clear_inputs();
    d_valid = 1; d_rs_addr = {5'd0, 5'd5}; d_rs_used = 2'b01;
    ex_rd = 5; ex_we = 1; ex_data = 32'h77;
    flush = 1;
    step();
    flush = 0; d_valid = 0;
    total_cnt++; if (e_valid !== 1'b0 || fwd_cnt !== 4'd4) $display("FAIL flush_accept got ev %0b cnt %0d exp 0/4", e_valid, fwd_cnt); else pass_cnt++;
    // accept a forwarded operand, then flush the held entry
    d_valid = 1;
    step();
    d_valid = 0; e_ready = 0;
    total_cnt++; if (e_valid !== 1'b1 || fwd_cnt !== 4'd5) $display("FAIL flush_prefill got ev %0b cnt %0d exp 1/5", e_valid, fwd_cnt); else pass_cnt++;
    flush = 1;
    step();
    flush = 0;
    total_cnt++; if (e_valid !== 1'b0) $display("FAIL flush_full got %0b exp 0", e_valid); else pass_cnt++;
    // fill again, then reset with a competing accept
    d_valid = 1;
    step();
    rst_n = 0;
    step();
    total_cnt++; if (e_valid !== 1'b0 || e_rs_data !== '0 || e_fwd_src !== '0) $display("FAIL reset_full got ev %0b %h %b exp 0 0 0", e_valid, e_rs_data, e_fwd_src); else pass_cnt++;
    total_cnt++; if (fwd_cnt !== 4'd0 || stall_cnt !== 4'd0) $display("FAIL reset_full_cnts got %0d/%0d exp 0/0", fwd_cnt, stall_cnt); else pass_cnt++;
    total_cnt++; if (d_ready !== 1'b1) $display("FAIL reset_full_d_ready got %0b exp 1", d_ready); else pass_cnt++;
    d_valid = 0; rst_n = 1;
    step();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    d_valid = 1; d_rs_addr = {5'd0, 5'd12}; d_rs_used = 2'b01;
    ex_rd = 12; ex_we = 1;
    for (int i = 1; i <= 17; i++) begin
      ex_data = 32'h100 + i;
      step();
      total_cnt++; if (e_valid !== 1'b1 || e_rs_data[31:0] !== 32'h100 + i) $display("FAIL b2b_data i %0d got ev %0b %h exp 1 %h", i, e_valid, e_rs_data[31:0], 32'h100 + i); else pass_cnt++;
    end
    d_valid = 0;
    total_cnt++; if (fwd_cnt !== 4'd15) $display("FAIL fwd_cnt_sat got %0d exp 15", fwd_cnt); else pass_cnt++;
    step();
  endtask

  task automatic test_stall_sat();
    clear_inputs();
    d_valid = 1; d_rs_addr = {5'd0, 5'd7}; d_rs_used = 2'b01;
    ex_rd = 7; ex_we = 1; ex_is_load = 1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) begin
        total_cnt++; if (stall_cnt !== 4'd14) $display("FAIL stall_cnt_14 got %0d exp 14", stall_cnt); else pass_cnt++;
      end
    end
    total_cnt++; if (stall_cnt !== 4'd15) $display("FAIL stall_cnt_sat got %0d exp 15", stall_cnt); else pass_cnt++;
    total_cnt++; if (e_valid !== 1'b0) $display("FAIL stall_no_issue got %0b exp 0", e_valid); else pass_cnt++;
    clear_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_ex_priority();
    test_priority_chain();
    test_zero_addr();
    test_load_use();
    test_backpressure();
    test_flush_and_reset();
    test_back_to_back();
    test_stall_sat();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/operand_fwd_stage.md
OPERAND_FWD_STAGE -- requirements
Module: operand_fwd_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand data width.
REQ-002 SHALL have parameter NPORT, default 2, meaning number of source-operand read ports (1..4).
REQ-003 SHALL have parameter AW, default 5, meaning register address width.
REQ-004 SHALL have parameter CW, default 16, meaning statistics counter width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 d_valid / d_ready  in / out  1 / 1  decode-side operand request handshake.
REQ-008 d_rs_addr  in  NPORT*AW  source register address per port.
REQ-009 d_rs_used  in  NPORT  port p operand is consumed by the instruction.
REQ-010 d_rf_data  in  NPORT*XLEN  register-file read data per port.
REQ-011 ex_rd, ex_we, ex_is_load, ex_data  in  AW,1,1,XLEN  EX-stage producer.
REQ-012 mem_rd, mem_we, mem_data  in  AW,1,XLEN  MEM-stage producer; data final.
REQ-013 wb_rd, wb_we, wb_data  in  AW,1,XLEN  WB-stage producer.
REQ-014 flush  in  1  discard held and incoming operands.
REQ-015 e_valid / e_ready  out / in  1 / 1  EX-side handshake.
REQ-016 e_rs_data  out  NPORT*XLEN  registered selected operands.
REQ-017 e_fwd_src  out  NPORT*2  registered source per port: 0 RF, 1 WB, 2 MEM, 3 EX.
REQ-018 fwd_cnt, stall_cnt  out  CW, CW  saturating statistics.

Function
REQ-019 Per port, selection SHALL be combinational with priority EX > MEM > WB > RF; a stage matches when its we=1, rd==rs_addr and rd!=0.
REQ-020 Address 0 SHALL always yield data 0 and src 0, regardless of d_rf_data or producers.
REQ-021 Load-use hazard SHALL be asserted when d_valid=1 and any port p has d_rs_used[p]=1 and matches EX with ex_is_load=1.
REQ-022 An unused port SHALL never cause hazard nor count as forwarded, but its selected data is still registered.
REQ-023 d_ready SHALL equal !hazard && (!e_valid || e_ready); accept = d_valid && d_ready.
REQ-024 The output stage SHALL be a one-entry register with states EMPTY (e_valid=0) and FULL (e_valid=1).
REQ-025 EMPTY->FULL on accept; FULL->FULL on accept with e_ready=1 (new data loaded); FULL->EMPTY on e_ready=1 without accept; FULL holds data unchanged while e_ready=0.
REQ-026 Latency d accept to e_valid SHALL be exactly one cycle; no combinational path from d_* to e_*.
REQ-027 flush=1 SHALL force next state EMPTY, overriding a simultaneous accept; that accept SHALL not update counters.
REQ-028 fwd_cnt SHALL increment by 1 per non-flushed accept with at least one used port sourced from a non-RF stage.
REQ-029 stall_cnt SHALL increment by 1 per cycle with hazard=1 and flush=0.
REQ-030 Both counters SHALL saturate at 2^CW-1 and not wrap.
REQ-031 e_rs_data and e_fwd_src SHALL be undefined-free: loaded only on accept, otherwise held.

Reset
REQ-032 With rst_n=0 at a rising edge: state EMPTY, e_valid=0, e_rs_data=0, e_fwd_src=0, fwd_cnt=0, stall_cnt=0.
REQ-033 Reset SHALL dominate flush and accept; an in-flight FULL entry is dropped.
REQ-034 d_ready SHALL follow REQ-023 combinationally during reset (state EMPTY, so 1 unless hazard).

Structure
REQ-035 Source encodings (RF/WB/MEM/EX) SHALL live in the shared pipeline package as named constants.
REQ-036 Per-port selection SHALL be one sub-module, fwd_sel_port, instantiated NPORT times via generate.
REQ-037 Hazard reduction, output register and counters SHALL reside in operand_fwd_stage.

Verification
REQ-038 rs1=5, ex_rd=5/we=1 data 0xAAAA, mem_rd=5 data 0xBBBB -> next cycle e_rs_data[0]=0xAAAA, src=3, fwd_cnt=1.
REQ-039 rs1=0, wb_rd=0 we=1 data 0x1234, rf=0xFFFF -> port0 data 0, src 0, fwd_cnt unchanged.
REQ-040 rs2=7 used, ex_rd=7 ex_is_load=1 for 1 cycle -> d_ready=0 that cycle, stall_cnt=1; next cycle mem_rd=7 data 0x55 -> accept, data 0x55 src 2.
REQ-041 FULL with e_ready=0 for 3 cycles, d_valid=1 -> e_rs_data stable, d_ready=0; e_ready=1 -> new operands loaded next cycle.
REQ-042 flush and accept same cycle -> e_valid=0 next cycle, counters unchanged; rst_n=0 while FULL -> all outputs 0.
REQ-043 CW=4, 20 consecutive hazard cycles -> stall_cnt stops at 15.
